// File: rtl/signed_mac_accumulator.sv
// signed_mac_accumulator: two-stage signed multiply-accumulate.
//   Stage 1 registers x*y from the combinational signed_multiplier.
//   Stage 2 accumulates products and emits one result per packet,
//   on the product flagged last.
// Optional feature: define MAC_SATURATE_EN to clamp on overflow and
// report it on ovf; otherwise the sum wraps and ovf stays 0.

module signed_multiplier #(
  parameter int N = 4
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  // Both operands are sign-extended to the full product width before multiplying
  assign p = (2*N)'($signed(a)) * (2*N)'($signed(b));

endmodule

module signed_mac_accumulator #(
  parameter int N     = 4,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     x,
  input  logic [N-1:0]     y,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [7:0]       out_count,
  output logic             ovf
);

  typedef enum logic [0:0] {
    ACC_IDLE = 1'b0,
    ACC_RUN  = 1'b1
  } acc_state_t;

  // Saturating term counter increment
  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    logic [7:0] r;
    if (c == 8'hFF) begin
      r = c;
    end else begin
      r = c + 8'd1;
    end
    return r;
  endfunction

  // Signed overflow of a+b: operands share a sign and the result sign differs
  function automatic logic add_ovf(input logic [ACC_W-1:0] a,
                                   input logic [ACC_W-1:0] b,
                                   input logic [ACC_W-1:0] s);
    return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
  endfunction

  // Clamp value for an overflowed sum; the sign of the addend picks the rail
  function automatic logic [ACC_W-1:0] clamp_val(input logic neg);
    logic [ACC_W-1:0] r;
    if (neg) begin
      r = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      r = {1'b0, {(ACC_W-1){1'b1}}};
    end
    return r;
  endfunction

  // Stage 1 state
  logic [2*N-1:0]   prod_s;
  logic [2*N-1:0]   p_r;
  logic             p_valid_r;
  logic             p_last_r;

  // Stage 2 state
  acc_state_t       state_r;
  acc_state_t       state_next_s;
  logic [ACC_W-1:0] acc_r;
  logic [7:0]       cnt_r;
  logic             ovf_acc_r;

  // Handshake and datapath nets
  logic             out_free_s;
  logic             p_take_s;
  logic             accept_s;
  logic [ACC_W-1:0] pext_s;
  logic [ACC_W-1:0] base_s;
  logic [7:0]       cnt_base_s;
  logic             ovf_base_s;
  logic [ACC_W-1:0] sum_s;
  logic             ovf_raw_s;
  logic [ACC_W-1:0] val_s;
  logic             ovf_now_s;
  logic [7:0]       cnt_next_s;

  signed_multiplier #(.N(N)) u_mul (
    .a (x),
    .b (y),
    .p (prod_s)
  );

  // Handshake: a last product may only leave stage 1 when the output register is free
  always_comb begin
    out_free_s = !out_valid || out_ready;
    p_take_s   = p_valid_r && (!p_last_r || out_free_s);
    in_ready   = !p_valid_r || p_take_s;
    accept_s   = in_valid && in_ready;
  end

  // Stage 1 product register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_r       <= {(2*N){1'b0}};
      p_valid_r <= 1'b0;
      p_last_r  <= 1'b0;
    end else if (accept_s) begin
      p_r       <= prod_s;
      p_valid_r <= 1'b1;
      p_last_r  <= in_last;
    end else if (p_take_s) begin
      p_valid_r <= 1'b0;
    end
  end

  // Accumulate datapath: sign-extended product added to the running sum
  always_comb begin
    pext_s = ACC_W'($signed(p_r));
    if (state_r == ACC_RUN) begin
      base_s     = acc_r;
      cnt_base_s = cnt_r;
      ovf_base_s = ovf_acc_r;
    end else begin
      base_s     = {ACC_W{1'b0}};
      cnt_base_s = 8'd0;
      ovf_base_s = 1'b0;
    end
    sum_s      = base_s + pext_s;
    ovf_raw_s  = add_ovf(base_s, pext_s, sum_s);
    cnt_next_s = sat_inc(cnt_base_s);
`ifdef MAC_SATURATE_EN
    if (ovf_raw_s) begin
      val_s = clamp_val(pext_s[ACC_W-1]);
    end else begin
      val_s = sum_s;
    end
    ovf_now_s = ovf_raw_s;
`else
    val_s     = sum_s;
    ovf_now_s = 1'b0;
`endif
  end

  // Accumulator FSM next state: RUN while a packet is open, IDLE after its last term
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ACC_IDLE: begin
        if (p_take_s && !p_last_r) begin
          state_next_s = ACC_RUN;
        end else begin
          state_next_s = ACC_IDLE;
        end
      end
      ACC_RUN: begin
        if (p_take_s && p_last_r) begin
          state_next_s = ACC_IDLE;
        end else begin
          state_next_s = ACC_RUN;
        end
      end
      default: begin
        state_next_s = ACC_IDLE;
      end
    endcase
  end

  // Accumulator FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ACC_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Running sum, term count and sticky overflow; cleared when a packet closes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r     <= {ACC_W{1'b0}};
      cnt_r     <= 8'd0;
      ovf_acc_r <= 1'b0;
    end else if (p_take_s) begin
      if (p_last_r) begin
        acc_r     <= {ACC_W{1'b0}};
        cnt_r     <= 8'd0;
        ovf_acc_r <= 1'b0;
      end else begin
        acc_r     <= val_s;
        cnt_r     <= cnt_next_s;
        ovf_acc_r <= ovf_base_s | ovf_now_s;
      end
    end
  end

  // Result register: loads on a last take, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      acc_out   <= {ACC_W{1'b0}};
      out_count <= 8'd0;
      ovf       <= 1'b0;
    end else if (p_take_s && p_last_r) begin
      out_valid <= 1'b1;
      acc_out   <= val_s;
      out_count <= cnt_next_s;
      ovf       <= ovf_base_s | ovf_now_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
